// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that packs bytes into words and fills instruction memory
// Holds the core in reset until a full frame with a matching XOR checksum has been written.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t      state;
   logic [15:0] len;
   logic [23:0] word_buf;
   logic [1:0]  byte_cnt;
   logic [7:0]  csum;
   logic        accept;
   logic [16:0] len_new;
   logic [16:0] len_max;
   logic [16:0] wc_next;

   assign accept  = in_valid && in_ready;
   assign len_new = {1'b0, in_data, len[7:0]};
   assign len_max = 17'd1 << ADDR_W;
   assign wc_next = 17'(word_count) + 17'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_SYNC;
         len        <= '0;
         word_buf   <= '0;
         byte_cnt   <= '0;
         csum       <= '0;
         in_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         word_count <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            S_SYNC: begin
               csum       <= '0;
               byte_cnt   <= '0;
               word_count <= '0;
               imem_addr  <= '0;
               if (accept && in_data == 8'hA5)
                  state <= S_LEN_LO;
            end
            S_LEN_LO: begin
               if (accept) begin
                  len[7:0] <= in_data;
                  state    <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               // Reject lengths that would wrap the address space before any write happens.
               if (accept) begin
                  len[15:8] <= in_data;
                  if (len_new > len_max) begin
                     state      <= S_ERROR;
                     in_ready   <= 1'b0;
                     load_error <= 1'b1;
                  end else if (len_new == 17'd0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  csum     <= csum ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_buf <= {in_data, word_buf[23:8]};
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_wdata <= {in_data, word_buf};
                     imem_addr  <= word_count[ADDR_W-1:0];
                     word_count <= word_count + 1'b1;
                     if (wc_next == {1'b0, len})
                        state <= S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                     cpu_hold  <= 1'b0;
                  end else begin
                     state      <= S_ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed frames
// Expected writes are queued by the stimulus and popped by an independent write monitor.
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   word_count;

   int errors = 0;
   int checks = 0;
   logic [39:0] exp_q[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error),
      .word_count (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            chk("write_addr", imem_addr, e[39:32]);
            chk("write_data", imem_wdata, e[31:0]);
            chk("write_count", word_count, e[39:32] + 1);
         end
      end
   end

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_low_mid_frame: got 0 expected 1");
      end
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input logic [7:0] bytes[$], input bit rnd);
      foreach (bytes[i]) send_byte(bytes[i], rnd ? int'($urandom_range(0, 2)) : 0);
      in_valid = 1'b0;
   endtask

   task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic chk_status(input string tag, input bit done, input bit err,
                             input bit hold, input bit rdy, input int wc);
      chk({tag, "_load_done"}, load_done, done);
      chk({tag, "_load_error"}, load_error, err);
      chk({tag, "_cpu_hold"}, cpu_hold, hold);
      chk({tag, "_in_ready"}, in_ready, rdy);
      chk({tag, "_word_count"}, word_count, wc);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] f[$];
      logic [7:0] x;
      logic [31:0] w;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      chk_status("reset", 0, 0, 1, 1, 0);
      chk("reset_we", imem_we, 0);
      chk("reset_addr", imem_addr, 0);
      chk("reset_wdata", imem_wdata, 0);

      // Two-word good frame, back-to-back
      expect_write(8'd0, 32'h44332211);
      expect_write(8'd1, 32'h88776655);
      f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      send_frame(f, 0);
      chk_status("good2", 1, 0, 0, 0, 2);
      chk("good2_last_addr", imem_addr, 1);

      // Same frame, bad checksum
      do_reset();
      expect_write(8'd0, 32'h44332211);
      expect_write(8'd1, 32'h88776655);
      f[11] = 8'h00;
      send_frame(f, 0);
      chk_status("badcsum", 0, 1, 1, 0, 2);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk_status("error_sticky", 0, 1, 1, 0, 2);

      // Garbage before sync, random in_valid gaps
      do_reset();
      expect_write(8'd0, 32'hEFBEADDE);
      f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
            8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      send_frame(f, 1);
      chk_status("garbage", 1, 0, 0, 0, 1);

      // Over-length N = 0x0101
      do_reset();
      f = '{8'hA5, 8'h01, 8'h01};
      send_frame(f, 0);
      chk_status("overlen", 0, 1, 1, 0, 0);

      // Maximum N = 0x0100
      do_reset();
      f = '{8'hA5, 8'h00, 8'h01};
      x = 8'h00;
      for (int i = 0; i < 256; i++) begin
         for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = 8'((i * 4 + k) * 7 + 3);
            f.push_back(w[8*k +: 8]);
            x = x ^ w[8*k +: 8];
         end
         expect_write(8'(i), w);
      end
      f.push_back(x);
      send_frame(f, 0);
      chk_status("maxlen", 1, 0, 0, 0, 256);
      chk("maxlen_last_addr", imem_addr, 255);

      // Empty frame
      do_reset();
      f = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(f, 0);
      chk_status("empty", 1, 0, 0, 0, 0);

      // Reset mid-frame, then a full frame
      do_reset();
      f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      send_frame(f, 0);
      do_reset();
      chk_status("midreset", 0, 0, 1, 1, 0);
      expect_write(8'd0, 32'hEFBEADDE);
      f = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      send_frame(f, 0);
      chk_status("after_midreset", 1, 0, 0, 0, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
